// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared constants and the per-stage bookkeeping record for the forwarding/hazard controller.
package fwd_hazard_ctrl_pkg;

    localparam int PKG_REG_AW = 5;

    // Operand mux select encoding; 2'b11 is never produced.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [PKG_REG_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [PKG_REG_AW-1:0] rd;
        logic                  regwrite;
        logic                  memread;
    } stage_info_t;

    localparam stage_info_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/fwd_hazard_ctrl_sel_calc.sv
// Priority compare of one source register against the EX and MEM stage writers.
// EX is checked first: its result is the newest value once the ID instruction reaches EX.
module fwd_sel_calc
    import fwd_hazard_ctrl_pkg::*;
(
    input  logic [PKG_REG_AW-1:0] src,
    input  logic [PKG_REG_AW-1:0] ex_rd,
    input  logic                  ex_regwrite,
    input  logic [PKG_REG_AW-1:0] mem_rd,
    input  logic                  mem_regwrite,
    output logic [1:0]            sel
);

    // Newest matching writer wins; register zero is never forwarded.
    always_comb begin
        sel = FWD_RF;
        if (ex_regwrite && (ex_rd != REG_ZERO) && (ex_rd == src)) begin
            sel = FWD_MEM;
        end else if (mem_regwrite && (mem_rd != REG_ZERO) && (mem_rd == src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard control for the EX-stage operand muxes.
// Tracks EX/MEM/WB destination info, registers forward selects on the ID->EX
// transfer and requests a one-cycle stall when a load in EX feeds the ID instruction.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = PKG_REG_AW,   // must match the package record width
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic [1:0]        forward_a_o,
    output logic [1:0]        forward_b_o,
    output logic              stall_o,
    output logic [REG_AW-1:0] mem_rd_o,
    output logic [REG_AW-1:0] wb_rd_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    stage_info_t id_info;
    stage_info_t ex_q;
    stage_info_t mem_q;
    stage_info_t wb_q;
    logic        bubble;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic        unused_bits;

    assign id_info = '{rd: id_rd_i, regwrite: id_regwrite_i, memread: id_memread_i};

    // Both rs and rt are compared regardless of whether the instruction reads them;
    // a taken branch squashes the consumer, so no stall is needed then.
    assign stall_o = ex_q.memread && (ex_q.rd != REG_ZERO)
                   && ((ex_q.rd == id_rs_i) || (ex_q.rd == id_rt_i))
                   && !flush_i;

    assign bubble = stall_o | flush_i;

    fwd_sel_calc u_sel_a (
        .src          (id_rs_i),
        .ex_rd        (ex_q.rd),
        .ex_regwrite  (ex_q.regwrite),
        .mem_rd       (mem_q.rd),
        .mem_regwrite (mem_q.regwrite),
        .sel          (sel_a)
    );

    fwd_sel_calc u_sel_b (
        .src          (id_rt_i),
        .ex_rd        (ex_q.rd),
        .ex_regwrite  (ex_q.regwrite),
        .mem_rd       (mem_q.rd),
        .mem_regwrite (mem_q.regwrite),
        .sel          (sel_b)
    );

    // Advance the stage records and register the selects for the instruction entering EX.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q        <= STAGE_BUBBLE;
            mem_q       <= STAGE_BUBBLE;
            wb_q        <= STAGE_BUBBLE;
            forward_a_o <= FWD_RF;
            forward_b_o <= FWD_RF;
        end else begin
            ex_q        <= bubble ? STAGE_BUBBLE : id_info;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            forward_a_o <= bubble ? FWD_RF : sel_a;
            forward_b_o <= bubble ? FWD_RF : sel_b;
        end
    end

    // Count stall cycles, holding at the maximum value.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (stall_o && (stall_cnt_o != CNT_MAX)) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

    assign mem_rd_o = mem_q.rd;
    assign wb_rd_o  = wb_q.rd;

    // Load/write flags past EX are carried for completeness but not needed here.
    assign unused_bits = ^{mem_q.memread, wb_q.regwrite, wb_q.memread};

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench: directed hazard scenarios plus random traffic, checked each
// cycle against an in-flight instruction list model.
module tb_fwd_hazard_ctrl;

    localparam int AW = 5;
    localparam int CW = 4;           // narrow counter so saturation is reachable
    localparam int CMAX = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic [AW-1:0] id_rs_i = '0;
    logic [AW-1:0] id_rt_i = '0;
    logic [AW-1:0] id_rd_i = '0;
    logic          id_regwrite_i = 1'b0;
    logic          id_memread_i = 1'b0;
    logic          flush_i = 1'b0;
    logic [1:0]    forward_a_o;
    logic [1:0]    forward_b_o;
    logic          stall_o;
    logic [AW-1:0] mem_rd_o;
    logic [AW-1:0] wb_rd_o;
    logic [CW-1:0] stall_cnt_o;

    fwd_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .id_rs_i       (id_rs_i),
        .id_rt_i       (id_rt_i),
        .id_rd_i       (id_rd_i),
        .id_regwrite_i (id_regwrite_i),
        .id_memread_i  (id_memread_i),
        .flush_i       (flush_i),
        .forward_a_o   (forward_a_o),
        .forward_b_o   (forward_b_o),
        .stall_o       (stall_o),
        .mem_rd_o      (mem_rd_o),
        .wb_rd_o       (wb_rd_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: list of instructions in EX, MEM, WB ----------
    typedef struct {
        int rd;
        bit wr;
        bit ld;
    } ins_t;

    ins_t pipe[3];      // [0]=EX, [1]=MEM, [2]=WB
    int   m_fa, m_fb, m_cnt;

    // Newest older writer of src among the instructions about to be in MEM / WB.
    function automatic int want_sel(input int src);
        for (int i = 0; i < 2; i++)
            if (pipe[i].wr && pipe[i].rd != 0 && pipe[i].rd == src)
                return (i == 0) ? 2 : 1;
        return 0;
    endfunction

    function automatic bit want_stall();
        return pipe[0].ld && pipe[0].rd != 0 &&
               (pipe[0].rd == int'(id_rs_i) || pipe[0].rd == int'(id_rt_i)) && !flush_i;
    endfunction

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < 3; i++) pipe[i] = '{0, 1'b0, 1'b0};
            m_fa = 0; m_fb = 0; m_cnt = 0;
        end else begin
            bit st, bub;
            ins_t nxt;
            st  = want_stall();
            bub = st || flush_i;
            m_fa = bub ? 0 : want_sel(int'(id_rs_i));
            m_fb = bub ? 0 : want_sel(int'(id_rt_i));
            if (st && m_cnt < CMAX) m_cnt++;
            nxt = bub ? '{0, 1'b0, 1'b0} : '{int'(id_rd_i), id_regwrite_i, id_memread_i};
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = nxt;
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk_i) begin
        if (rst_i) begin
            chk("cyc_fwd_a", int'(forward_a_o), m_fa);
            chk("cyc_fwd_b", int'(forward_b_o), m_fb);
            chk("cyc_stall", int'(stall_o), int'(want_stall()));
            chk("cyc_mem_rd", int'(mem_rd_o), pipe[1].rd);
            chk("cyc_wb_rd", int'(wb_rd_o), pipe[2].rd);
            chk("cyc_cnt", int'(stall_cnt_o), m_cnt);
        end
    end

    // Present one ID instruction and let it be captured by the next rising edge.
    task automatic cyc(input int rs, input int rt, input int rd, input bit wr,
                       input bit ld, input bit fl);
        id_rs_i = AW'(rs); id_rt_i = AW'(rt); id_rd_i = AW'(rd);
        id_regwrite_i = wr; id_memread_i = ld; flush_i = fl;
        @(posedge clk_i); #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with random inputs applied.
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            id_rs_i = AW'($urandom); id_rt_i = AW'($urandom); id_rd_i = AW'($urandom);
            id_regwrite_i = 1'($urandom); id_memread_i = 1'($urandom); flush_i = 1'($urandom);
            @(negedge clk_i);
        end
        chk("rst_fwd_a", int'(forward_a_o), 0);
        chk("rst_fwd_b", int'(forward_b_o), 0);
        chk("rst_stall", int'(stall_o), 0);
        chk("rst_cnt", int'(stall_cnt_o), 0);
        id_memread_i = 1'b0; flush_i = 1'b0;
        #2 rst_i = 1'b1;
        @(posedge clk_i); #1;
        nops(3);

        // EX->EX: add $3 then sub $x,$3,$4.
        cyc(1, 2, 3, 1'b1, 1'b0, 1'b0);
        cyc(3, 4, 6, 1'b1, 1'b0, 1'b0);
        chk("exex_fwd_a", int'(forward_a_o), 2);
        chk("exex_fwd_b", int'(forward_b_o), 0);
        nops(3);

        // Two writers of $5: newest wins.
        cyc(0, 0, 5, 1'b1, 1'b0, 1'b0);
        cyc(0, 0, 5, 1'b1, 1'b0, 1'b0);
        cyc(5, 5, 7, 1'b1, 1'b0, 1'b0);
        chk("prio_fwd_a", int'(forward_a_o), 2);
        chk("prio_fwd_b", int'(forward_b_o), 2);
        nops(3);

        // Only the older writer.
        cyc(0, 0, 5, 1'b1, 1'b0, 1'b0);
        cyc(0, 0, 0, 1'b0, 1'b0, 1'b0);
        cyc(5, 5, 7, 1'b1, 1'b0, 1'b0);
        chk("memex_fwd_a", int'(forward_a_o), 1);
        chk("memex_fwd_b", int'(forward_b_o), 1);
        nops(3);

        // Load-use: lw $2 then a consumer of $2.
        cyc(0, 0, 2, 1'b1, 1'b1, 1'b0);
        id_rs_i = 5'd2; id_rt_i = 5'd7; id_rd_i = 5'd8; id_regwrite_i = 1'b1; id_memread_i = 1'b0;
        #1;
        chk("lu_stall_on", int'(stall_o), 1);
        chk("lu_cnt_before", int'(stall_cnt_o), 0);
        @(posedge clk_i); #1;
        chk("lu_stall_off", int'(stall_o), 0);
        chk("lu_cnt_after", int'(stall_cnt_o), 1);
        chk("lu_bubble_fwd", int'(forward_a_o), 0);
        @(posedge clk_i); #1;
        chk("lu_dep_fwd_a", int'(forward_a_o), 1);
        chk("lu_dep_fwd_b", int'(forward_b_o), 0);
        nops(3);

        // Register zero is never forwarded nor causes a stall.
        cyc(0, 0, 0, 1'b1, 1'b0, 1'b0);
        cyc(0, 0, 9, 1'b1, 1'b0, 1'b0);
        chk("zero_fwd_a", int'(forward_a_o), 0);
        chk("zero_fwd_b", int'(forward_b_o), 0);
        nops(3);
        cyc(0, 0, 0, 1'b1, 1'b1, 1'b0);
        id_rs_i = 5'd0; id_rt_i = 5'd0; #1;
        chk("zero_load_stall", int'(stall_o), 0);
        nops(3);

        // Flush beats load-use.
        cyc(0, 0, 2, 1'b1, 1'b1, 1'b0);
        id_rs_i = 5'd2; id_rt_i = 5'd2; id_rd_i = 5'd3; id_regwrite_i = 1'b1;
        id_memread_i = 1'b0; flush_i = 1'b1; #1;
        chk("flush_stall", int'(stall_o), 0);
        @(posedge clk_i); #1;
        chk("flush_cnt", int'(stall_cnt_o), 1);
        chk("flush_fwd_a", int'(forward_a_o), 0);
        chk("flush_fwd_b", int'(forward_b_o), 0);
        flush_i = 1'b0;
        nops(3);

        // Reset asserted in the middle of a stall.
        cyc(0, 0, 9, 1'b1, 1'b1, 1'b0);
        cyc(0, 0, 4, 1'b1, 1'b0, 1'b0);
        id_rs_i = 5'd4; id_rt_i = 5'd4; id_rd_i = 5'd1; id_memread_i = 1'b0;
        // EX holds a non-load now; put a load in EX and a consumer in ID.
        cyc(0, 0, 9, 1'b1, 1'b1, 1'b0);
        id_rs_i = 5'd9; id_rt_i = 5'd1; id_rd_i = 5'd1; id_memread_i = 1'b0; #1;
        chk("mid_stall_on", int'(stall_o), 1);
        rst_i = 1'b0; #1;
        chk("arst_stall", int'(stall_o), 0);
        chk("arst_fwd_a", int'(forward_a_o), 0);
        chk("arst_fwd_b", int'(forward_b_o), 0);
        chk("arst_cnt", int'(stall_cnt_o), 0);
        chk("arst_mem_rd", int'(mem_rd_o), 0);
        chk("arst_wb_rd", int'(wb_rd_o), 0);
        @(negedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk("post_rst_stall", int'(stall_o), 0);
        nops(3);

        // Drive the counter into saturation.
        for (int i = 0; i < CMAX + 3; i++) begin
            cyc(0, 0, 4, 1'b1, 1'b1, 1'b0);
            cyc(4, 0, 6, 1'b1, 1'b0, 1'b0);
            cyc(4, 0, 6, 1'b1, 1'b0, 1'b0);
        end
        chk("sat_cnt", int'(stall_cnt_o), CMAX);
        nops(3);

        // Random traffic over a small register set to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Control stage directly upstream of the EX-stage 3-to-1 operand muxes in the pipelined CPU.
- Tracks destination register, RegWrite and MemRead of the instructions in flight in EX, MEM and WB.
- Produces registered forward selects for the instruction in EX, a load-use stall request for IF/ID, and a saturating stall counter.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, stall counter width.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- id_rs_i  in  REG_AW  rs of the instruction in ID.
- id_rt_i  in  REG_AW  rt of the instruction in ID.
- id_rd_i  in  REG_AW  resolved destination of the ID instruction (RegDst already applied).
- id_regwrite_i  in  1  ID instruction writes the register file.
- id_memread_i  in  1  ID instruction is a load.
- flush_i  in  1  branch taken; the ID instruction is squashed.
- forward_a_o  out  2  select for the ALU src A mux.
- forward_b_o  out  2  select for the ALU src B mux.
- stall_o  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
- mem_rd_o  out  REG_AW  destination of the instruction in MEM.
- wb_rd_o  out  REG_AW  destination of the instruction in WB.
- stall_cnt_o  out  CNT_W  number of stall cycles since reset, saturating.

Behaviour:
- Fixed clock/reset: one clock; reset is asynchronous and active-low (clk_i, rst_i).
- Reset (rst_i=0) clears, asynchronously:
  - all stage registers: rd=0, regwrite=0, memread=0;
  - forward_a_o and forward_b_o to 2'b00;
  - stall_cnt_o to 0.
  - stall_o then reads 0.
- Forward select encoding, matching the mux inputs:
  - 00: register-file read data;
  - 01: MEM/WB write-back data;
  - 10: EX/MEM ALU result;
  - 11: never driven.
- Internal stage registers, updated every cycle:
  - EX <= ID fields, or a bubble (all zero) when bubble = stall_o | flush_i;
  - MEM <= EX;
  - WB <= MEM.
- Forward selects are registered, computed on the ID->EX transfer. For src A (src B identical, using id_rt_i):
  - 10 if EX.regwrite, EX.rd != 0 and EX.rd == id_rs_i (that instruction moves to MEM next cycle);
  - else 01 if MEM.regwrite, MEM.rd != 0 and MEM.rd == id_rs_i;
  - else 00.
  - MEM-stage match has priority over WB-stage match.
  - On a bubble, both selects register 00.
- The instruction in WB during the ID read needs no forwarding: the register file is write-first in the same cycle.
- stall_o is combinational: EX.memread & EX.rd != 0 & (EX.rd == id_rs_i | EX.rd == id_rt_i) & !flush_i.
  - rs and rt are always compared (conservative); no per-instruction use flags.
- Load-use sequence: load in EX, dependent in ID -> exactly one stall cycle. Next cycle the load is in MEM and EX holds a bubble, so stall_o=0. The dependent then enters EX with select 01 (load data from WB).
- Simultaneous flush_i and load-use: flush wins. stall_o=0, bubble inserted, stall not counted.
- stall_cnt_o increments by 1 on each clock edge with stall_o=1 and holds at 2^CNT_W-1.
- Reset mid-stall: all state clears immediately; the first post-reset cycle has stall_o=0.
- Latency: forward selects are valid in the same cycle the instruction occupies EX (one clock after ID).

Decomposition:
- Shared package constants:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - REG_ZERO=5'd0.
  - Stage-info record type {rd, regwrite, memread}.
- One sub-module, fwd_sel_calc: combinational priority compare of one source register against two stage records, producing a 2-bit select. Instantiated twice, for A and B.

Test Plan:
- Reset: hold rst_i=0 with random inputs -> forward_a_o = forward_b_o = 00, stall_o=0, stall_cnt_o=0.
- EX->EX hazard: add $3 in ID (regwrite, rd=3), next cycle sub with rs=3, rt=4 -> when sub is in EX, forward_a_o=10, forward_b_o=00.
- MEM->EX hazard with priority: writes to $5 two back and one back, next rs=rt=5 -> both selects 10. Same case with only the older writer -> both 01.
- Load-use: lw $2 in EX (memread, rd=2), ID rs=2 -> stall_o=1 for exactly one cycle, stall_cnt_o 0->1, then dependent in EX with forward_a_o=01.
- Register zero: writer with rd=0, consumer rs=0 -> selects 00. Load to $0 -> stall_o=0.
- Flush vs stall: load-use condition with flush_i=1 -> stall_o=0, stall_cnt_o unchanged, next EX selects 00. Then pulse rst_i low during a stall -> all outputs cleared asynchronously.
